// File: rtl/osd_stm_pkg.sv
// Shared definitions for the STM trace arbiter.
//   LOST_ID       : trace id carried by a drop report
//   ID_W          : width of a trace id
//   DROP_PORT_W   : width of the port-index field in a drop report
//   gnt_kind_e    : what the arbiter granted in a cycle
// Drop report value layout (XLEN bits, zero-extended):
//   [DROPW+DROP_PORT_W-1:DROPW] port index, [DROPW-1:0] drop count.
package osd_stm_pkg;

  localparam int          ID_W        = 16;
  localparam logic [15:0] LOST_ID     = 16'hFFFF;
  localparam int          DROP_PORT_W = 4;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_EVENT = 2'd1,
    GNT_DROP  = 2'd2
  } gnt_kind_e;

  // Classify the winner of a cycle: a full buffer always goes out as an
  // event; an empty buffer can only have won because of its drop counter.
  function automatic gnt_kind_e classify_grant(input logic any, input logic buf_full);
    if (!any)          return GNT_NONE;
    else if (buf_full) return GNT_EVENT;
    else               return GNT_DROP;
  endfunction

endpackage

// File: rtl/osd_rr_arbiter.sv
// Round-robin arbiter with rotating priority.
//   clk, rst : clock and synchronous active-high reset
//   req      : per-port request vector
//   gnt      : one-hot grant (all zero when no request)
//   gnt_idx  : binary index of the granted port
//   gnt_any  : at least one port granted
// Priority starts at the port after the last granted one; port 0 after reset.
module osd_rr_arbiter #(
  parameter int NPORTS = 4,
  parameter int IDXW   = $clog2(NPORTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NPORTS-1:0] req,
  output logic [NPORTS-1:0] gnt,
  output logic [IDXW-1:0]   gnt_idx,
  output logic              gnt_any
);

  logic [IDXW-1:0] ptr_q;
  logic [IDXW-1:0] ptr_d;
  int              j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    // Walk the ports starting at the pointer, wrapping at NPORTS.
    for (int i = 0; i < NPORTS; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NPORTS) j = j - NPORTS;
      if (!gnt_any && req[j]) begin
        gnt_any = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IDXW'(j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (int'(gnt_idx) == NPORTS - 1) ? '0 : gnt_idx + IDXW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/osd_stm_trace_arb.sv
// Merges NPORTS fire-and-forget trace requesters onto one STM trace input.
//   clk, rst     : clock, synchronous active-high reset
//   enable       : accept new requester events when 1
//   req_valid    : per-port event strobe
//   req_id       : per-port 16-bit id, port p at [16p+15:16p]
//   req_value    : per-port value, port p at [XLEN*p+XLEN-1:XLEN*p]
//   trace_valid  : merged event strobe (registered)
//   trace_id     : merged event id (held when idle)
//   trace_value  : merged event value (held when idle)
//   drop_pending : per-port "drop counter nonzero" (registered)
// Each port owns a one-entry buffer and a saturating drop counter. Events
// arriving on a full, non-granted buffer are discarded and counted; the
// count is later reported as a LOST_ID event once the buffer is empty.
module osd_stm_trace_arb
  import osd_stm_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int XLEN   = 64,
  parameter int DROPW  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [NPORTS-1:0]      req_valid,
  input  logic [NPORTS*16-1:0]   req_id,
  input  logic [NPORTS*XLEN-1:0] req_value,
  output logic                   trace_valid,
  output logic [15:0]            trace_id,
  output logic [XLEN-1:0]        trace_value,
  output logic [NPORTS-1:0]      drop_pending
);

  localparam int IDXW = $clog2(NPORTS);

  function automatic logic [DROPW-1:0] sat_inc(input logic [DROPW-1:0] v);
    return (&v) ? v : v + DROPW'(1);
  endfunction

  function automatic logic [XLEN-1:0] drop_report(input logic [IDXW-1:0]  port,
                                                  input logic [DROPW-1:0] cnt);
    logic [XLEN-1:0] r;
    r                        = '0;
    r[DROPW-1:0]             = cnt;
    r[DROPW +: DROP_PORT_W]  = DROP_PORT_W'(port);
    return r;
  endfunction

  logic              buf_vld_q   [NPORTS];
  logic              buf_vld_d   [NPORTS];
  logic [ID_W-1:0]   buf_id_q    [NPORTS];
  logic [ID_W-1:0]   buf_id_d    [NPORTS];
  logic [XLEN-1:0]   buf_val_q   [NPORTS];
  logic [XLEN-1:0]   buf_val_d   [NPORTS];
  logic [DROPW-1:0]  drop_cnt_q  [NPORTS];
  logic [DROPW-1:0]  drop_cnt_d  [NPORTS];

  logic              trace_valid_q, trace_valid_d;
  logic [ID_W-1:0]   trace_id_q,    trace_id_d;
  logic [XLEN-1:0]   trace_value_q, trace_value_d;
  logic [NPORTS-1:0] drop_pending_q, drop_pending_d;

  logic [NPORTS-1:0] cand;
  logic [NPORTS-1:0] gnt;
  logic [IDXW-1:0]   gnt_idx;
  logic              gnt_any;
  gnt_kind_e         gnt_kind;

  // A nonzero counter only makes a candidate once its buffer is empty, but
  // a full buffer is a candidate anyway, so the OR below is equivalent.
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      cand[p] = buf_vld_q[p] | (drop_cnt_q[p] != '0);
    end
  end

  osd_rr_arbiter #(
    .NPORTS (NPORTS),
    .IDXW   (IDXW)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (cand),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Output select: buffered event or drop report of the granted port.
  always_comb begin
    gnt_kind      = classify_grant(gnt_any, buf_vld_q[gnt_idx]);
    trace_valid_d = gnt_any;
    trace_id_d    = trace_id_q;
    trace_value_d = trace_value_q;
    case (gnt_kind)
      GNT_EVENT: begin
        trace_id_d    = buf_id_q[gnt_idx];
        trace_value_d = buf_val_q[gnt_idx];
      end
      GNT_DROP: begin
        trace_id_d    = LOST_ID;
        trace_value_d = drop_report(gnt_idx, drop_cnt_q[gnt_idx]);
      end
      default: ;
    endcase
  end

  // Per-port buffer and drop-counter update.
  always_comb begin
    logic             take;
    logic             drop;
    logic [DROPW-1:0] cnt_base;
    take     = 1'b0;
    drop     = 1'b0;
    cnt_base = '0;
    for (int p = 0; p < NPORTS; p++) begin
      // A granted buffer frees its slot this cycle, so it can reload at once.
      buf_vld_d[p] = buf_vld_q[p] & ~gnt[p];
      buf_id_d[p]  = buf_id_q[p];
      buf_val_d[p] = buf_val_q[p];
      take         = enable & req_valid[p];
      drop         = take & buf_vld_d[p];
      if (take && !buf_vld_d[p]) begin
        buf_vld_d[p] = 1'b1;
        buf_id_d[p]  = req_id[16*p +: 16];
        buf_val_d[p] = req_value[XLEN*p +: XLEN];
      end
      // A report clears the counter; a drop in the same cycle restarts at 1.
      cnt_base          = (gnt[p] && !buf_vld_q[p]) ? '0 : drop_cnt_q[p];
      drop_cnt_d[p]     = drop ? sat_inc(cnt_base) : cnt_base;
      drop_pending_d[p] = (drop_cnt_d[p] != '0);
    end
  end

  // Register stage: control state and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      trace_valid_q  <= 1'b0;
      trace_id_q     <= '0;
      trace_value_q  <= '0;
      drop_pending_q <= '0;
      for (int p = 0; p < NPORTS; p++) begin
        buf_vld_q[p]  <= 1'b0;
        drop_cnt_q[p] <= '0;
      end
    end else begin
      trace_valid_q  <= trace_valid_d;
      trace_id_q     <= trace_id_d;
      trace_value_q  <= trace_value_d;
      drop_pending_q <= drop_pending_d;
      for (int p = 0; p < NPORTS; p++) begin
        buf_vld_q[p]  <= buf_vld_d[p];
        drop_cnt_q[p] <= drop_cnt_d[p];
      end
    end
  end

  // Buffer payload is qualified by buf_vld_q and needs no reset.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORTS; p++) begin
      buf_id_q[p]  <= buf_id_d[p];
      buf_val_q[p] <= buf_val_d[p];
    end
  end

  assign trace_valid  = trace_valid_q;
  assign trace_id     = trace_id_q;
  assign trace_value  = trace_value_q;
  assign drop_pending = drop_pending_q;

endmodule
